// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one single-port unified memory between the fetch port and
// the load/store port. One transaction is in flight at a time. Data normally
// wins, but an instruction request that has waited through STARVE_MAX
// consecutive data grants takes the next grant.
module imem_dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_valid,
  output logic              inst_stall,
  // load/store port
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic              data_stall,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              r_inst_valid;
  logic              r_data_valid;
  logic [CNT_W-1:0]  r_starve_cnt;

  state_t            w_state_nxt;
  logic              w_mem_req_nxt;
  logic              w_mem_we_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic [DATA_W-1:0] w_inst_rdata_nxt;
  logic [DATA_W-1:0] w_data_rdata_nxt;
  logic              w_inst_valid_nxt;
  logic              w_data_valid_nxt;
  logic [CNT_W-1:0]  w_starve_cnt_nxt;
  logic              w_grant_d;
  logic              w_grant_i;

  // Grant decision: data first unless the fetch port has been starved.
  always_comb begin
    w_grant_d = data_req && (!inst_req || (r_starve_cnt < STARVE_LIM));
    w_grant_i = !w_grant_d && inst_req;
  end

  // Next-state and next-output logic; mem_* hold while a transaction is open.
  always_comb begin
    w_state_nxt      = r_state;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_inst_rdata_nxt = r_inst_rdata;
    w_data_rdata_nxt = r_data_rdata;
    w_inst_valid_nxt = 1'b0;
    w_data_valid_nxt = 1'b0;
    w_starve_cnt_nxt = r_starve_cnt;

    unique case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt     = SERVE_D;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = data_we;
          w_mem_addr_nxt  = data_addr;
          w_mem_wdata_nxt = data_wdata;
          if (inst_req) begin
            if (r_starve_cnt < STARVE_LIM) begin
              w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
            end
          end else begin
            w_starve_cnt_nxt = '0;
          end
        end else if (w_grant_i) begin
          w_state_nxt      = SERVE_I;
          w_mem_req_nxt    = 1'b1;
          w_mem_we_nxt     = 1'b0;
          w_mem_addr_nxt   = inst_addr;
          w_mem_wdata_nxt  = '0;
          w_starve_cnt_nxt = '0;
        end
      end

      SERVE_I: begin
        if (mem_ack) begin
          w_state_nxt      = IDLE;
          w_mem_req_nxt    = 1'b0;
          w_inst_valid_nxt = 1'b1;
          w_inst_rdata_nxt = mem_rdata;
        end
      end

      SERVE_D: begin
        if (mem_ack) begin
          w_state_nxt      = IDLE;
          w_mem_req_nxt    = 1'b0;
          w_data_valid_nxt = 1'b1;
          if (!r_mem_we) begin
            w_data_rdata_nxt = mem_rdata;
          end
        end
      end

      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any open transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_inst_valid <= 1'b0;
      r_data_valid <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_inst_rdata <= w_inst_rdata_nxt;
      r_data_rdata <= w_data_rdata_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign inst_rdata = r_inst_rdata;
  assign data_rdata = r_data_rdata;
  assign inst_valid = r_inst_valid;
  assign data_valid = r_data_valid;

  // Stalls release in the same cycle the completion pulse is seen.
  assign inst_stall = inst_req & ~r_inst_valid;
  assign data_stall = data_req & ~r_data_valid;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: request agents, a memory model with
// programmable ack delay, and queues of expected transactions and read data.
module tb_imem_dmem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_valid, inst_stall;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_we, data_valid, data_stall;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_valid(inst_valid), .inst_stall(inst_stall),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_valid(data_valid), .data_stall(data_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t           inst_pend[$];
  op_t           data_pend[$];
  op_t           txn_exp[$];
  logic [DW-1:0] inst_exp[$];
  logic [DW-1:0] data_exp[$];
  op_t           cur_txn;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            ack_delay = 1;
  int            ack_cnt = 0;
  bit            model_en = 1'b1;
  logic          prev_mem_req = 1'b0;
  logic [DW-1:0] last_load = '0;
  int            inst_raise_cyc = 0, data_raise_cyc = 0;
  int            inst_lat = 0, data_lat = 0;

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == '0) return 32'h0050_0093;
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic queue_inst(input logic [AW-1:0] a);
    op_t o;
    o.we = 1'b0; o.addr = a; o.wdata = '0;
    inst_pend.push_back(o);
    inst_exp.push_back(mem_val(a));
  endtask

  task automatic queue_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    op_t o;
    o.we = we; o.addr = a; o.wdata = wd;
    data_pend.push_back(o);
    if (!we) last_load = mem_val(a);
    data_exp.push_back(last_load);
  endtask

  task automatic expect_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    op_t o;
    o.we = we; o.addr = a; o.wdata = wd;
    txn_exp.push_back(o);
  endtask

  // One clock: check outputs, run the memory model, then update requesters.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (inst_valid) begin
      if (inst_exp.size() == 0) check_eq("inst_valid_spurious", 32'd1, 32'd0);
      else check_eq("inst_rdata", inst_rdata, inst_exp.pop_front());
      inst_lat = cyc - inst_raise_cyc;
    end
    if (data_valid) begin
      if (data_exp.size() == 0) check_eq("data_valid_spurious", 32'd1, 32'd0);
      else check_eq("data_rdata", data_rdata, data_exp.pop_front());
      data_lat = cyc - data_raise_cyc;
    end
    if (mem_req && !prev_mem_req) begin
      if (txn_exp.size() == 0) check_eq("mem_req_unexpected", 32'd1, 32'd0);
      else cur_txn = txn_exp.pop_front();
    end
    if (mem_req) begin
      check_eq("mem_addr", mem_addr, cur_txn.addr);
      check_eq("mem_we", {31'd0, mem_we}, {31'd0, cur_txn.we});
      check_eq("mem_wdata", mem_wdata, cur_txn.wdata);
    end
    prev_mem_req = mem_req;
    check_eq("inst_stall", {31'd0, inst_stall}, {31'd0, inst_req & ~inst_valid});
    check_eq("data_stall", {31'd0, data_stall}, {31'd0, data_req & ~data_valid});

    mem_rdata = 32'hBAD0_BAD0;
    if (model_en) begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        ack_cnt = 0;
      end else if (mem_req) begin
        if (ack_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val(mem_addr);
        end else begin
          ack_cnt++;
        end
      end
    end

    if (inst_valid && inst_pend.size() > 0) begin
      void'(inst_pend.pop_front());
      inst_req = 1'b0;
    end
    if (!inst_req && inst_pend.size() > 0) begin
      inst_req = 1'b1; inst_addr = inst_pend[0].addr; inst_raise_cyc = cyc;
    end
    if (data_valid && data_pend.size() > 0) begin
      void'(data_pend.pop_front());
      data_req = 1'b0;
    end
    if (!data_req && data_pend.size() > 0) begin
      data_req = 1'b1; data_we = data_pend[0].we; data_addr = data_pend[0].addr;
      data_wdata = data_pend[0].wdata; data_raise_cyc = cyc;
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (inst_pend.size() == 0 && data_pend.size() == 0 && txn_exp.size() == 0 &&
          inst_exp.size() == 0 && data_exp.size() == 0 && !inst_req && !data_req && !mem_req) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {31'd0, done}, 32'd1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_req"},    {31'd0, mem_req},    32'd0);
    check_eq({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
    check_eq({tag, "_mem_addr"},   mem_addr,            32'd0);
    check_eq({tag, "_mem_wdata"},  mem_wdata,           32'd0);
    check_eq({tag, "_inst_rdata"}, inst_rdata,          32'd0);
    check_eq({tag, "_data_rdata"}, data_rdata,          32'd0);
    check_eq({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    check_eq({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] saved_load;
    bit            seen;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    cur_txn.we = 1'b0; cur_txn.addr = '0; cur_txn.wdata = '0;
    #12;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single fetch, ack one cycle after mem_req: valid 3 cycles after request.
    expect_txn(1'b0, 32'h0, 32'h0);
    queue_inst(32'h0);
    wait_idle("t1_drain");
    check_eq("t1_latency", inst_lat, 32'd3);

    // Simultaneous requests: data first, then fetch.
    expect_txn(1'b0, 32'h100, 32'h0);
    expect_txn(1'b0, 32'h04, 32'h0);
    queue_data(1'b0, 32'h100, 32'h0);
    queue_inst(32'h04);
    wait_idle("t2_drain");

    // Continuous data with a waiting fetch: four data grants, then fetch.
    for (int i = 0; i < 4; i++) expect_txn(1'b0, 32'h300 + 32'(4 * i), 32'h0);
    expect_txn(1'b0, 32'h08, 32'h0);
    expect_txn(1'b0, 32'h310, 32'h0);
    for (int i = 0; i < 5; i++) queue_data(1'b0, 32'h300 + 32'(4 * i), 32'h0);
    queue_inst(32'h08);
    wait_idle("t3_drain");

    // Starvation count cleared: a fresh simultaneous pair again favours data.
    expect_txn(1'b0, 32'h110, 32'h0);
    expect_txn(1'b0, 32'h0C, 32'h0);
    queue_data(1'b0, 32'h110, 32'h0);
    queue_inst(32'h0C);
    wait_idle("t3b_drain");

    // Store: write fields held until ack, data_rdata keeps the last load.
    ack_delay = 2;
    expect_txn(1'b1, 32'h200, 32'hDEAD_BEEF);
    queue_data(1'b1, 32'h200, 32'hDEAD_BEEF);
    wait_idle("t4_drain");
    check_eq("t4_rdata_kept", data_rdata, mem_val(32'h110));

    // Reset in the middle of a load, then a stray ack in IDLE.
    ack_delay = 3;
    saved_load = last_load;
    expect_txn(1'b0, 32'h400, 32'h0);
    queue_data(1'b0, 32'h400, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("t5_in_serve", {31'd0, seen}, 32'd1);
    model_en = 1'b0;
    mem_ack = 1'b0;
    #2;
    rst = 1'b1;
    data_req = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    #2;
    rst = 1'b0;
    data_pend.delete();
    data_exp.delete();
    last_load = saved_load;
    tick();
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    check_eq("t5_no_data_valid", {31'd0, data_valid}, 32'd0);
    check_eq("t5_no_inst_valid", {31'd0, inst_valid}, 32'd0);
    check_eq("t5_idle_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    check_eq("t5_no_data_valid2", {31'd0, data_valid}, 32'd0);
    check_eq("t5_data_rdata_zero", data_rdata, 32'd0);
    model_en = 1'b1;
    ack_cnt = 0;
    ack_delay = 1;
    expect_txn(1'b0, 32'h404, 32'h0);
    queue_data(1'b0, 32'h404, 32'h0);
    wait_idle("t5_drain");
    check_eq("t5_latency", data_lat, 32'd3);

    // Slow memory: ack five cycles after mem_req, fields stable throughout.
    ack_delay = 5;
    expect_txn(1'b0, 32'h80, 32'h0);
    queue_inst(32'h80);
    wait_idle("t6_drain");
    check_eq("t6_latency", inst_lat, 32'd7);
    check_eq("t6_inst_rdata_hold", inst_rdata, mem_val(32'h80));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
